// File: rtl/data_mem_resp.sv
// Data-memory responder: word-addressed synchronous RAM with a fixed read latency,
// plus a byte-stream loader port that fills memory sequentially before the core runs.
module data_mem_resp #(
  parameter int ADDR_W   = 17,
  parameter int DEPTH_W  = 15,
  parameter int READ_LAT = 2   // legal range 1..4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic              d_en,
  input  logic              d_we,
  output logic [31:0]       d_rdata,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  output logic              ld_ready,
  output logic [DEPTH_W:0]  ld_words,
  output logic              err
);

  localparam int DEPTH = 2 ** DEPTH_W;
  localparam logic [DEPTH_W:0] WORDS_MAX = {1'b1, {DEPTH_W{1'b0}}};

  logic [31:0]        mem [DEPTH];
  logic [31:0]        rd_pipe [READ_LAT];

  logic               ready_q;
  logic               commit_q;
  logic [1:0]         cnt_q;
  logic [31:0]        asm_q;
  logic [DEPTH_W-1:0] ptr_q;
  logic [DEPTH_W:0]   words_q;
  logic               err_q;

  logic [DEPTH_W-1:0] core_idx;
  logic               byte_acc;
  logic               commit_en;
  logic               core_wr;
  logic               unused_addr_hi;

  // Upper address bits alias onto the implemented depth.
  assign core_idx       = d_addr[DEPTH_W-1:0];
  assign unused_addr_hi = ^d_addr[ADDR_W-1:DEPTH_W];

  // ld_start wins over both a presented byte and a pending commit.
  assign byte_acc  = ld_valid & ld_ready & ~ld_start;
  assign commit_en = commit_q & ~ld_start;
  assign core_wr   = d_en & d_we;

  assign ld_ready = ready_q & ~commit_q;
  assign ld_words = words_q;
  assign err      = err_q;
  assign d_rdata  = rd_pipe[READ_LAT-1];

  // NOTE: the RAM array has no reset so it maps onto block RAM; contents survive rstn.
  // Single write port: a loader commit takes it, dropping any core write that cycle.
  always_ff @(posedge clk) begin
    if (commit_en) begin
      mem[ptr_q] <= asm_q;
    end else if (core_wr) begin
      mem[core_idx] <= d_wdata;
    end
  end

  // Stage 0 is the RAM read register (read-first); it only reloads on a request,
  // so idle cycles shift the last read value through and d_rdata holds it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < READ_LAT; i++) rd_pipe[i] <= '0;
    end else begin
      if (d_en) rd_pipe[0] <= mem[core_idx];
      for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ready_q  <= 1'b0;
      commit_q <= 1'b0;
      cnt_q    <= '0;
      asm_q    <= '0;
      ptr_q    <= '0;
      words_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (ld_start) begin
        commit_q <= 1'b0;
        cnt_q    <= '0;
        ptr_q    <= '0;
        words_q  <= '0;
      end else begin
        if (commit_q) begin
          commit_q <= 1'b0;
          ptr_q    <= ptr_q + DEPTH_W'(1);
          if (words_q != WORDS_MAX) words_q <= words_q + (DEPTH_W+1)'(1);
        end
        // byte_acc and commit_q never coincide because ld_ready is low while committing.
        if (byte_acc) begin
          asm_q <= {asm_q[23:0], ld_byte};
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) commit_q <= 1'b1;
        end
      end
      if (commit_en && core_wr) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed self-checking bench for data_mem_resp at the default parameters
// (READ_LAT=2, DEPTH_W=15); inputs change on negedge, outputs are sampled on negedge.
module tb_data_mem_resp;

  logic        clk;
  logic        rstn;
  logic [16:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_en;
  logic        d_we;
  logic [31:0] d_rdata;
  logic        ld_start;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_ready;
  logic [15:0] ld_words;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;

  data_mem_resp dut (
    .clk      (clk),
    .rstn     (rstn),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_en     (d_en),
    .d_we     (d_we),
    .d_rdata  (d_rdata),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_byte  (ld_byte),
    .ld_ready (ld_ready),
    .ld_words (ld_words),
    .err      (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic write_word(input logic [16:0] addr, input logic [31:0] data);
    @(negedge clk);
    d_en = 1'b1; d_we = 1'b1; d_addr = addr; d_wdata = data;
    @(negedge clk);
    d_en = 1'b0; d_we = 1'b0;
  endtask

  // Request at one negedge, sample two negedges later (READ_LAT=2).
  task automatic read_check(input string tag, input logic [16:0] addr, input logic [31:0] exp);
    @(negedge clk);
    d_en = 1'b1; d_we = 1'b0; d_addr = addr;
    @(negedge clk);
    d_en = 1'b0;
    @(negedge clk);
    check(tag, d_rdata, exp);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    ld_start = 1'b1; ld_valid = 1'b0;
    @(negedge clk);
    ld_start = 1'b0;
  endtask

  // Presents the top n bytes of word, MSB first; returns with the last byte still driven.
  task automatic send_bytes(input logic [31:0] word, input int n);
    int waits;
    for (int i = 0; i < n; i++) begin
      waits = 0;
      @(negedge clk);
      while (!ld_ready && waits < 8) begin
        ld_valid = 1'b0;
        waits++;
        @(negedge clk);
      end
      if (!ld_ready) check("ld_ready_wait", 32'(ld_ready), 32'd1);
      ld_valid = 1'b1;
      ld_byte  = word[31-8*i -: 8];
    end
  endtask

  initial begin
    logic [16:0] stream_addr [3];
    logic [31:0] stream_exp  [4];
    logic        exp_rdy     [10];
    int          idx;

    stream_addr = '{17'd5, 17'd6, 17'd5};
    stream_exp  = '{32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF};
    exp_rdy     = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // NOTE: bench drives inputs with blocking assignments on negedge, well clear of
    // the posedge the DUT samples on, so there is no race with its non-blocking updates.
    rstn = 1'b1; d_addr = '0; d_wdata = '0; d_en = 1'b0; d_we = 1'b0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_byte = '0;
    #2 rstn = 1'b0;

    // Reset with random activity on the inputs.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      d_addr = 17'($urandom); d_wdata = $urandom; d_en = 1'($urandom); d_we = 1'($urandom);
      ld_start = 1'($urandom); ld_valid = 1'($urandom); ld_byte = 8'($urandom);
    end
    @(posedge clk); #1;
    check("rst_rdata", d_rdata, 32'h0);
    check("rst_words", 32'(ld_words), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_ready", 32'(ld_ready), 32'h0);
    @(negedge clk);
    d_en = 1'b0; d_we = 1'b0; ld_start = 1'b0; ld_valid = 1'b0;
    rstn = 1'b1;
    #1 check("ready_before_edge", 32'(ld_ready), 32'h0);
    @(posedge clk); #1;
    check("ready_after_edge", 32'(ld_ready), 32'h1);

    // Write at edge 0, read at edge 1, sample before edge 3.
    @(negedge clk);
    d_en = 1'b1; d_we = 1'b1; d_addr = 17'd5; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    d_we = 1'b0;
    @(negedge clk);
    d_en = 1'b0;
    @(negedge clk);
    check("wr_rd_5", d_rdata, 32'hDEADBEEF);

    // Back-to-back reads 5, 6, 5 then idle: one result per cycle, then hold.
    write_word(17'd6, 32'h12345678);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c >= 2) check($sformatf("stream_%0d", c - 2), d_rdata, stream_exp[c-2]);
      if (c < 3) begin
        d_en = 1'b1; d_we = 1'b0; d_addr = stream_addr[c];
      end else begin
        d_en = 1'b0;
      end
    end

    // Read-during-write returns old data; the following read sees the new data.
    write_word(17'd9, 32'h11);
    @(negedge clk);
    d_en = 1'b1; d_we = 1'b1; d_addr = 17'd9; d_wdata = 32'h22;
    @(negedge clk);
    d_we = 1'b0;
    @(negedge clk);
    d_en = 1'b0;
    check("rdw_old", d_rdata, 32'h11);
    @(negedge clk);
    check("rdw_new", d_rdata, 32'h22);

    // Address aliasing above DEPTH_W.
    write_word(17'h08003, 32'hA5A5A5A5);
    read_check("alias", 17'h00003, 32'hA5A5A5A5);

    // Loader: eight bytes, ld_ready drops for the commit cycle after each 4th byte.
    pulse_start();
    idx = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("ld_ready_%0d", k), 32'(ld_ready), 32'(exp_rdy[k]));
      if (k == 5) check("ld_words_1", 32'(ld_words), 32'd1);
      if (idx < 8) begin
        ld_valid = 1'b1;
        ld_byte  = 8'(idx + 1);
        if (ld_ready) idx++;
      end else begin
        ld_valid = 1'b0;
      end
    end
    @(negedge clk);
    ld_valid = 1'b0;
    check("ld_words_2", 32'(ld_words), 32'd2);
    read_check("ld_mem0", 17'd0, 32'h01020304);
    read_check("ld_mem1", 17'd1, 32'h05060708);

    // Collision: core write to addr 0 during the loader commit to addr 0.
    pulse_start();
    send_bytes(32'hAABBCCDD, 4);
    @(negedge clk);
    ld_valid = 1'b0;
    check("coll_ready_low", 32'(ld_ready), 32'h0);
    check("coll_err_before", 32'(err), 32'h0);
    d_en = 1'b1; d_we = 1'b1; d_addr = 17'd0; d_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    d_en = 1'b0; d_we = 1'b0;
    check("coll_err_set", 32'(err), 32'h1);
    read_check("coll_mem0", 17'd0, 32'hAABBCCDD);

    // Partial word discarded by ld_start; a byte alongside ld_start is not accepted.
    pulse_start();
    send_bytes(32'h11220000, 2);
    @(negedge clk);
    ld_start = 1'b1; ld_valid = 1'b1; ld_byte = 8'h99;
    @(negedge clk);
    ld_start = 1'b0; ld_valid = 1'b0;
    send_bytes(32'h33445566, 4);
    @(negedge clk);
    ld_valid = 1'b0;
    @(negedge clk);
    check("restart_words", 32'(ld_words), 32'd1);
    read_check("restart_mem0", 17'd0, 32'h33445566);
    check("err_sticky", 32'(err), 32'h1);

    // ld_start in the commit cycle cancels the pending write to mem[1].
    send_bytes(32'h77777777, 4);
    @(negedge clk);
    ld_valid = 1'b0; ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    check("cancel_words", 32'(ld_words), 32'd0);
    read_check("cancel_mem1", 17'd1, 32'h05060708);

    // Reset clears err and counters but keeps RAM contents.
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rst2_err", 32'(err), 32'h0);
    check("rst2_rdata", d_rdata, 32'h0);
    check("rst2_ready", 32'(ld_ready), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    read_check("rst2_mem0_kept", 17'd0, 32'h33445566);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
